// File: rtl/core_run_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// core_run_ctrl_pkg
//   Shared types and constants for the core run-control block.
//   - run_state_e            : 2-bit core run state (RUN, WFI, HALT, FAULT)
//   - IRQ_SYNC_STAGES_DEFAULT: default depth of the irq synchronizer
//   - state_is_halted()      : HALT and FAULT both report as halted
// ----------------------------------------------------------------------------
package core_run_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    WFI   = 2'd1,
    HALT  = 2'd2,
    FAULT = 2'd3
  } run_state_e;

  localparam int IRQ_SYNC_STAGES_DEFAULT = 2;

  function automatic logic state_is_halted(input run_state_e s);
    return (s == HALT) || (s == FAULT);
  endfunction

endpackage

// File: rtl/core_run_ctrl_sync_ff.sv
// ----------------------------------------------------------------------------
// sync_ff
//   Multi-flop synchronizer for a single asynchronous level signal.
//   Ports:
//     clk   - destination clock
//     reset - asynchronous, active-high; clears every stage
//     d     - asynchronous input level
//     q     - synchronized level (last stage of the chain)
//   Parameter STAGES is the chain depth; anything below 2 is raised to 2
//   since a single flop gives no metastability protection.
// ----------------------------------------------------------------------------
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  localparam int DEPTH = (STAGES < 2) ? 2 : STAGES;

  logic [DEPTH-1:0] sync_reg;
  logic [DEPTH-1:0] sync_next;

  // Each stage samples the one before it; stage 0 samples the raw input.
  assign sync_next[0] = d;

  generate
    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
      assign sync_next[gi] = sync_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= sync_next;
    end
  end

  assign q = sync_reg[DEPTH-1];

endmodule

// File: rtl/core_run_ctrl.sv
// ----------------------------------------------------------------------------
// core_run_ctrl
//   Run-control and status block between the core and the control plane.
//   Synchronizes the external interrupt, tracks RUN / WFI / HALT / FAULT,
//   drives the core clock-gate enable and exports registered status.
//   Ports:
//     clk            - core clock
//     reset          - asynchronous, active-high reset (state -> RUN)
//     irq            - external interrupt level, asynchronous to clk
//     te             - test enable, forces the clock gate open
//     core_wfi_req   - pulse: core retired WFI
//     core_halt_req  - pulse: core requests halt
//     core_fault_req - pulse: core hit an unrecoverable fault
//     resume         - pulse: control plane releases a halted core
//     irq_pending    - synchronized irq
//     clk_en         - core clock-gate enable (combinational)
//     halted         - state is HALT or FAULT
//     fault          - state is FAULT (sticky until reset)
//     wfi            - state is WFI
// ----------------------------------------------------------------------------
module core_run_ctrl
  import core_run_ctrl_pkg::*;
#(
  parameter int IRQ_SYNC_STAGES = IRQ_SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic irq,
  input  logic te,
  input  logic core_wfi_req,
  input  logic core_halt_req,
  input  logic core_fault_req,
  input  logic resume,
  output logic irq_pending,
  output logic clk_en,
  output logic halted,
  output logic fault,
  output logic wfi
);

  run_state_e state_reg;
  run_state_e state_next;
  logic       wfi_reg;
  logic       halted_reg;
  logic       fault_reg;

  sync_ff #(
    .STAGES (IRQ_SYNC_STAGES)
  ) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (irq),
    .q     (irq_pending)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        // fault outranks halt, halt outranks wfi; a WFI retired while an
        // interrupt is already pending falls straight through.
        if (core_fault_req) begin
          state_next = FAULT;
        end else if (core_halt_req) begin
          state_next = HALT;
        end else if (core_wfi_req && !irq_pending) begin
          state_next = WFI;
        end
      end
      WFI: begin
        if (irq_pending) begin
          state_next = RUN;
        end
      end
      HALT: begin
        // A halted core is only released by the control plane, not by irq.
        if (resume) begin
          state_next = RUN;
        end
      end
      FAULT: begin
        state_next = FAULT;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Status flops decode the next state so they move on the same edge as
  // the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= RUN;
      wfi_reg    <= 1'b0;
      halted_reg <= 1'b0;
      fault_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      wfi_reg    <= (state_next == WFI);
      halted_reg <= state_is_halted(state_next);
      fault_reg  <= (state_next == FAULT);
    end
  end

  assign clk_en = te | (state_reg == RUN);
  assign wfi    = wfi_reg;
  assign halted = halted_reg;
  assign fault  = fault_reg;

endmodule

// File: tb/tb_core_run_ctrl.sv
// ----------------------------------------------------------------------------
// tb_core_run_ctrl
//   Directed bench for core_run_ctrl. Observed vector per check is
//   {irq_pending, clk_en, halted, fault, wfi}.
// ----------------------------------------------------------------------------
module tb_core_run_ctrl;
  import core_run_ctrl_pkg::*;

  logic clk;
  logic reset;
  logic irq;
  logic te;
  logic core_wfi_req;
  logic core_halt_req;
  logic core_fault_req;
  logic resume;
  logic irq_pending;
  logic clk_en;
  logic halted;
  logic fault;
  logic wfi;

  typedef struct {
    string      tag;
    logic [4:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp;
  int   n_err;

  core_run_ctrl #(
    .IRQ_SYNC_STAGES (IRQ_SYNC_STAGES_DEFAULT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .irq            (irq),
    .te             (te),
    .core_wfi_req   (core_wfi_req),
    .core_halt_req  (core_halt_req),
    .core_fault_req (core_fault_req),
    .resume         (resume),
    .irq_pending    (irq_pending),
    .clk_en         (clk_en),
    .halted         (halted),
    .fault          (fault),
    .wfi            (wfi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_out(input string tag, input logic [4:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs now.
  task automatic check_out();
    exp_t       e;
    logic [4:0] obs;
    e   = exp_q.pop_front();
    obs = {irq_pending, clk_en, halted, fault, wfi};
    n_cmp++;
    assert (obs === e.val) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", e.tag, obs, e.val);
    end
    $display("check %-14s obs=%b exp=%b", e.tag, obs, e.val);
  endtask

  task automatic chk(input string tag, input logic [4:0] val);
    expect_out(tag, val);
    check_out();
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    reset          = 1'b0;
    irq            = 1'b1;
    te             = 1'b0;
    core_wfi_req   = 1'b0;
    core_halt_req  = 1'b0;
    core_fault_req = 1'b0;
    resume         = 1'b0;

    // Reset asserted mid-cycle takes effect with no clock edge.
    #2 reset = 1'b1;
    #1 chk("reset_async", 5'b01000);
    step(2);
    chk("reset_held", 5'b01000);
    reset = 1'b0;
    step(1);
    chk("sync_edge1", 5'b01000);
    step(1);
    chk("sync_edge2", 5'b11000);

    // Sleep in WFI with no interrupt pending.
    irq = 1'b0;
    step(2);
    chk("irq_low", 5'b01000);
    core_wfi_req = 1'b1;
    step(1);
    core_wfi_req = 1'b0;
    chk("wfi_enter", 5'b00001);

    // Wake: irq rises before edge N, RUN after edge N+2.
    irq = 1'b1;
    step(1);
    chk("wake_n", 5'b00001);
    step(1);
    chk("wake_n1", 5'b10001);
    step(1);
    chk("wake_n2", 5'b11000);

    // WFI falls through while irq is pending.
    core_wfi_req = 1'b1;
    step(1);
    core_wfi_req = 1'b0;
    chk("wfi_fallthru", 5'b11000);
    step(1);
    chk("wfi_ft_hold", 5'b11000);

    // Test enable opens the gate in WFI without touching status.
    irq = 1'b0;
    step(2);
    core_wfi_req = 1'b1;
    step(1);
    core_wfi_req = 1'b0;
    chk("te_wfi", 5'b00001);
    te = 1'b1;
    #1 chk("te_on", 5'b01001);
    step(1);
    chk("te_on_edge", 5'b01001);
    te = 1'b0;
    #1 chk("te_off", 5'b00001);
    irq = 1'b1;
    step(3);
    chk("te_wake", 5'b11000);
    irq = 1'b0;
    step(2);

    // Halt, irq does not wake, core_* ignored, resume releases.
    core_halt_req = 1'b1;
    step(1);
    core_halt_req = 1'b0;
    chk("halt_enter", 5'b00100);
    irq = 1'b1;
    step(3);
    chk("halt_irq", 5'b10100);
    core_wfi_req = 1'b1;
    step(1);
    core_wfi_req = 1'b0;
    chk("halt_ign_wfi", 5'b10100);
    resume = 1'b1;
    step(1);
    resume = 1'b0;
    chk("halt_resume", 5'b11000);
    irq = 1'b0;
    step(2);

    // Resume in RUN is ignored.
    resume = 1'b1;
    step(1);
    resume = 1'b0;
    chk("run_resume", 5'b01000);

    // All three requests together: fault wins and is terminal.
    core_fault_req = 1'b1;
    core_halt_req  = 1'b1;
    core_wfi_req   = 1'b1;
    step(1);
    core_fault_req = 1'b0;
    core_halt_req  = 1'b0;
    core_wfi_req   = 1'b0;
    chk("prio_fault", 5'b00110);
    resume = 1'b1;
    step(1);
    resume = 1'b0;
    chk("fault_resume", 5'b00110);
    irq = 1'b1;
    step(2);
    core_halt_req = 1'b1;
    step(1);
    core_halt_req = 1'b0;
    core_wfi_req  = 1'b1;
    step(1);
    core_wfi_req = 1'b0;
    chk("fault_sticky", 5'b10110);
    te = 1'b1;
    #1 chk("fault_te", 5'b11110);
    te = 1'b0;

    // Reset mid-FAULT returns to RUN immediately.
    #1 reset = 1'b1;
    #1 chk("reset_fault", 5'b01000);
    step(1);
    reset = 1'b0;
    step(2);
    chk("post_reset", 5'b11000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
